// File: rtl/dot_seq_pkg.sv
// Shared types and default sizing for the dot-product sequencer.
package dot_seq_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_MAX_LEN    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/dot_seq_ctrl_mac_dp.sv
// Two-stage MAC datapath: registered product with a valid flag, then a wrapping accumulator.
module mac_dp
    import dot_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    output logic [2*DATA_WIDTH-1:0] acc
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic                    prod_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else if (clear) begin
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_valid <= en;
            if (en) begin
                prod <= (2*DATA_WIDTH)'(operand_a) * (2*DATA_WIDTH)'(operand_b);
            end
            if (prod_valid) begin
                acc <= acc + prod;
            end
        end
    end

endmodule

// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: pulls operand pairs, drives the MAC datapath, drains it and presents the sum.
module dot_seq_ctrl
    import dot_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_LEN    = DEFAULT_MAX_LEN,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   operand_a,
    input  logic [DATA_WIDTH-1:0]   operand_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] result
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 clear;
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        busy        = (state_q != IDLE);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = (len > LEN_MAX) ? LEN_MAX : len;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // The last product lands in the accumulator during this single cycle.
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mac_dp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac_dp (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (accept),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .acc       (result)
    );

endmodule

// File: doc/dot_seq_ctrl.md
Name: dot_seq_ctrl

Overview:
- Sequencer for the multiply-accumulate datapath. It computes one dot product of a requested length from a streamed sequence of operand pairs.
- Accepts a start command with a vector length, then pulls operand pairs over a valid/ready handshake.
- Drives a 2-stage MAC datapath (product register, then accumulator) with explicit clear and enable, waits for the pipeline to drain, and presents the result on a valid/ready output.
- Sits between the operand source (memory/stream front-end) and the result consumer.

Parameters:
- DATA_WIDTH, 4, operand width in bits.
- MAX_LEN, 16, maximum vector length per command.
- LEN_WIDTH, $clog2(MAX_LEN+1), width of the len port.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset. Single clock domain.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_WIDTH  vector length, sampled with start.
- busy  out  1  high whenever state is not IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts a pair this cycle.
- operand_a  in  DATA_WIDTH  unsigned operand A.
- operand_b  in  DATA_WIDTH  unsigned operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*DATA_WIDTH  dot product, unsigned, modulo 2^(2*DATA_WIDTH).

Behaviour:
- States: IDLE, LOAD, DRAIN, DONE.
- Reset values: state=IDLE; busy=0, in_ready=0, out_valid=0, result=0; remaining count=0; product register and its valid flag=0; accumulator=0.
- IDLE:
  - start=1 and len>0: latch min(len, MAX_LEN) into the remaining counter, clear the accumulator and product valid, go to LOAD.
  - start=1 and len=0: clear the accumulator, go directly to DONE (result 0).
  - len>MAX_LEN is clamped to MAX_LEN.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid & in_ready) registers operand_a*operand_b into the product register (product valid=1) and decrements remaining.
  - No handshake leaves product valid=0.
  - The handshake that takes remaining to 0 moves the state to DRAIN.
  - Gaps in in_valid are allowed and stall without corrupting the sum.
- Datapath: each cycle with product valid=1, accumulator <= accumulator + product. Width is 2*DATA_WIDTH and overflow wraps silently.
- DRAIN:
  - in_ready=0.
  - Lasts exactly 1 cycle, during which the last product is accumulated.
  - Then go to DONE.
- DONE:
  - out_valid=1; result = accumulator, held stable until out_ready.
  - out_ready=1 moves the state to IDLE, with out_valid=0 the next cycle.
  - start asserted in DONE is ignored, even when coincident with out_ready.
  - result keeps its last value in IDLE.
- start outside IDLE is ignored; no queuing.
- in_ready is 0 in every state except LOAD. operand_a/operand_b are don't-care when there is no handshake.
- Latency: start at cycle 0, len=N, in_valid held high → accepts in cycles 1..N, DRAIN in cycle N+1, out_valid first high in cycle N+2. For len=0, out_valid is high in cycle 1.
- Reset mid-operation: all state and in-flight products are discarded; behaviour matches the reset values above on the next cycle.

Decomposition:
- Package dot_seq_pkg:
  - state enum state_t {IDLE, LOAD, DRAIN, DONE}.
  - Default width constants.
- Sub-module mac_dp: product register plus accumulator.
  - Ports: clk, reset, clear, en, operand_a, operand_b, acc.
  - en marks the operand pair as valid for the product stage; the accumulator adds only products whose valid flag is set.
- The controller holds the FSM, remaining counter and handshakes.

Test Plan:
- Basic: start with len=3, pairs (2,3),(4,5),(1,7) back-to-back → result=33, out_valid rises at cycle 5, in_ready low from cycle 4.
- Wrap: len=2, pairs (15,15),(15,15) → result=450 mod 256 = 194.
- Stalls/backpressure:
  - len=4, all pairs (3,3), in_valid toggling 1,0,1,0… → result=36, exactly 4 handshakes.
  - out_ready held low 5 cycles → result and out_valid stable; a start pulse during DONE is ignored and busy stays 1.
- Edge lengths:
  - len=0 → out_valid in cycle 1, result=0.
  - len=20 → exactly 16 pairs accepted (all (1,1)), result=16.
- Reset mid-LOAD: after 2 of 5 pairs, pulse reset → next cycle busy=0, in_ready=0, out_valid=0, result=0. A fresh len=1 run with pair (5,6) gives result=30.
